multi_channel_noise_filter: RTL
===============================

MULTI_CHANNEL_NOISE_FILTER -- requirements
Module: multi_channel_noise_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width (signed two's complement, 8..24).
REQ-002 SHALL have parameter CH, default 4, channel count (1..8).
REQ-003 SHALL have parameter CH_W, default 2, channel index width, $clog2(CH) minimum 1.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports s_valid in 1, s_ready out 1, s_data in DATA_W, s_ch in CH_W: input sample stream.
REQ-007 SHALL have ports m_valid out 1, m_ready in 1, m_data out DATA_W, m_ch out CH_W: filtered output stream.
REQ-008 SHALL have ports cfg_we in 1, cfg_addr in 4, cfg_wdata in 16, cfg_rdata out 16: register port.

Function
REQ-009 SHALL use the register map: 0..CH-1 alpha[ch] (unsigned Q1.15); 8 enable mask [CH-1:0]; 9 clear (write-only, 1 bit per channel); other addresses read 0 and ignore writes.
REQ-010 SHALL clamp alpha writes above 0x8000 to 0x8000 (1.0, pass-through).
REQ-011 SHALL return cfg_rdata one cycle after cfg_addr is presented; address 9 reads 0.
REQ-012 SHALL accept a sample when s_valid && s_ready; s_ready = !stage1_full || advance, where advance = !m_valid || m_ready.
REQ-013 SHALL be a two-stage pipeline: stage 1 latches sample, reads state y[ch], computes diff = x - y (DATA_W+1 bits); stage 2 computes y_new and loads the m_* output register; latency from accept to m_valid is 2 cycles with no backpressure.
REQ-014 SHALL compute y_new = y + ((alpha*diff + 2^14) >>> 15), arithmetic shift, saturated to signed DATA_W.
REQ-015 SHALL forward stage-2 y_new into stage 1 when consecutive accepted samples share a channel, so every sample sees the most recent state.
REQ-016 SHALL load y[ch] = x and output x for the first sample after reset or clear of that channel (primed[ch] set).
REQ-017 SHALL output x unfiltered and load y[ch] = x when enable[ch] = 0.
REQ-018 SHALL apply a config write to samples entering stage 1 on the following cycle or later; same-cycle accept uses the old value.
REQ-019 SHALL apply a clear coinciding with a stage-2 update of the same channel after that update (channel ends unprimed).
REQ-020 SHALL hold m_data, m_ch and m_valid stable while m_valid && !m_ready.
REQ-021 SHALL preserve per-channel output order equal to input order.

Reset
REQ-022 SHALL on reset set m_valid 0, m_data 0, m_ch 0, cfg_rdata 0, stage-1 valid 0, alpha[*] 0x2000, enable mask all ones, primed[*] 0, y[*] 0, deadband 0.
REQ-023 SHALL discard any in-flight samples on reset asserted mid-operation; the first output after deassertion comes from a newly accepted sample.

Configuration
REQ-024 SHALL, with MCNF_DEADBAND_EN defined, add register 10 deadband (unsigned DATA_W-1 bits); when |diff| <= deadband, output y and leave y[ch] unchanged (primed and bypassed channels unaffected).
REQ-025 SHALL, without MCNF_DEADBAND_EN, treat address 10 as unmapped (reads 0), with no deadband logic synthesised.

Verification
REQ-026 SHALL test: ch0 alpha 0x2000, back-to-back samples 0x4000, 0x0000, 0x0000 -> m_data 0x4000, 0x3000, 0x2400, outputs 2 cycles after each accept.
REQ-027 SHALL test: interleaved ch0 = 0x1000, ch1 = -0x1000, then ch0 = 0, ch1 = 0 -> 0x1000, 0xF000, 0x0C00, 0xF400 with correct m_ch.
REQ-028 SHALL test: m_ready low for 3 cycles with 3 samples offered -> m_data held, s_ready drops after two samples are in flight, no loss or duplication.
REQ-029 SHALL test: alpha write 0xFFFF reads back 0x8000, and a following ch0 sample 0x1234 outputs 0x1234; enable[1] = 0 passes ch1 samples unchanged.
REQ-030 SHALL test: reset pulsed with both stages full -> m_valid 0 next cycle, first post-reset ch0 sample 0x0100 outputs 0x0100 (unprimed).
REQ-031 SHALL test, with MCNF_DEADBAND_EN: deadband 0x0010, ch0 primed at 0x1000, sample 0x1008 -> output 0x1000; sample 0x1100 -> output 0x1040.

Source files
------------

// File: rtl/multi_channel_noise_filter.sv
// Per-channel first-order IIR noise filter: y += alpha*(x - y), two-stage stream pipeline.
// Optional deadband register (address 10) when MCNF_DEADBAND_EN is defined.
module multi_channel_noise_filter #(
   parameter int DATA_W = 16,
   parameter int CH     = 4,
   parameter int CH_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic [CH_W-1:0]   s_ch,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [CH_W-1:0]   m_ch,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [15:0]       cfg_wdata,
   output logic [15:0]       cfg_rdata
);
   localparam int PW = DATA_W + 18;
   localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

   logic [15:0]              alpha [CH];
   logic [CH-1:0]            enable, primed;
   logic signed [DATA_W-1:0] y_st [CH];
`ifdef MCNF_DEADBAND_EN
   logic [DATA_W-2:0]        deadband;
`endif

   // vld_pipe[1] = stage-1 occupied, vld_pipe[2] = output register occupied
   logic [2:1]               vld_pipe;
   logic signed [DATA_W-1:0] s1_x, s1_y;
   logic signed [DATA_W:0]   s1_diff;
   logic [15:0]              s1_alpha;
   logic [CH_W-1:0]          s1_ch;
   logic                     s1_en, s1_first;

   logic advance, upd, accept, fwd;
   assign advance = !vld_pipe[2] || m_ready;
   assign upd     = vld_pipe[1] && advance;
   assign s_ready = !vld_pipe[1] || advance;
   assign accept  = s_valid && s_ready;
   assign m_valid = vld_pipe[2];
   assign fwd     = upd && (s1_ch == s_ch);

   // stage 2: filter arithmetic on the stage-1 registers
   logic signed [PW-1:0]     prod, delta, sum;
   logic signed [DATA_W-1:0] y_sat, y_next;
   logic [DATA_W:0]          adiff;
   logic                     hold;
   always_comb begin
      prod  = PW'($signed({1'b0, s1_alpha})) * PW'(s1_diff);
      delta = (prod + PW'(2 ** 14)) >>> 15;
      sum   = PW'(s1_y) + delta;
      if (sum > SAT_MAX)      y_sat = SAT_MAX[DATA_W-1:0];
      else if (sum < SAT_MIN) y_sat = SAT_MIN[DATA_W-1:0];
      else                    y_sat = sum[DATA_W-1:0];
      adiff = s1_diff[DATA_W] ? $unsigned(-s1_diff) : $unsigned(s1_diff);
`ifdef MCNF_DEADBAND_EN
      hold = s1_en && !s1_first && (adiff <= {2'b00, deadband});
`else
      hold = 1'b0;
`endif
      if (s1_first || !s1_en) y_next = s1_x;
      else if (hold)          y_next = s1_y;
      else                    y_next = y_sat;
   end

   // stage 1 lookup, with the in-flight update forwarded for a same-channel follower
   logic signed [DATA_W-1:0] y_rd;
   logic signed [DATA_W:0]   diff_rd;
   logic                     first_rd;
   always_comb begin
      y_rd     = fwd ? y_next : y_st[s_ch];
      first_rd = fwd ? 1'b0 : !primed[s_ch];
      diff_rd  = $signed({s_data[DATA_W-1], s_data}) - $signed({y_rd[DATA_W-1], y_rd});
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_diff  <= '0;
         s1_alpha <= '0;
         s1_ch    <= '0;
         s1_en    <= 1'b0;
         s1_first <= 1'b0;
         m_data   <= '0;
         m_ch     <= '0;
      end else begin
         if (s_ready) vld_pipe[1] <= s_valid;
         if (accept) begin
            s1_x     <= s_data;
            s1_y     <= y_rd;
            s1_diff  <= diff_rd;
            s1_alpha <= alpha[s_ch];
            s1_ch    <= s_ch;
            s1_en    <= enable[s_ch];
            s1_first <= first_rd;
         end
         if (advance) vld_pipe[2] <= vld_pipe[1];
         if (upd) begin
            m_data <= y_next;
            m_ch   <= s1_ch;
         end
      end
   end

   // channel state and config registers; a clear lands after a same-cycle update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable <= '1;
         primed <= '0;
         for (int i = 0; i < CH; i++) begin
            alpha[i] <= 16'h2000;
            y_st[i]  <= '0;
         end
`ifdef MCNF_DEADBAND_EN
         deadband <= '0;
`endif
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (upd && s1_ch == CH_W'(i)) begin
               y_st[i]   <= y_next;
               primed[i] <= 1'b1;
            end
            if (cfg_we && cfg_addr == 4'd9 && cfg_wdata[i]) begin
               y_st[i]   <= '0;
               primed[i] <= 1'b0;
            end
            if (cfg_we && cfg_addr == 4'(i))
               alpha[i] <= (cfg_wdata > 16'h8000) ? 16'h8000 : cfg_wdata;
         end
         if (cfg_we && cfg_addr == 4'd8) enable <= cfg_wdata[CH-1:0];
`ifdef MCNF_DEADBAND_EN
         if (cfg_we && cfg_addr == 4'd10) deadband <= (DATA_W - 1)'(cfg_wdata);
`endif
      end
   end

   logic [15:0] rd_mux;
   always_comb begin
      rd_mux = '0;
      if (int'(cfg_addr) < CH)  rd_mux = alpha[cfg_addr[CH_W-1:0]];
      else if (cfg_addr == 4'd8) rd_mux = 16'(enable);
`ifdef MCNF_DEADBAND_EN
      else if (cfg_addr == 4'd10) rd_mux = 16'(deadband);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cfg_rdata <= '0;
      else       cfg_rdata <= rd_mux;
   end
endmodule
